// File: rtl/rb_sched_pkg.sv
// ----------------------------------------------------------------------------
// rb_sched_pkg
// Shared definitions for the ring-buffer write scheduler:
//   - default configuration values
//   - scheduler state encoding
//   - ring-buffer address type (default address width)
//   - helpers deriving the event block size and block count
// ----------------------------------------------------------------------------
package rb_sched_pkg;

    localparam int ADDR_W_DEF      = 10;
    localparam int NCHAN_DEF       = 16;
    localparam int NSAMP_DEF       = 8;
    localparam int HOLD_MARGIN_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    typedef logic [ADDR_W_DEF-1:0] rb_addr_t;

    // Words per event block: one sample per channel per sample time.
    function automatic int calc_blk(input int nchan, input int nsamp);
        return nchan * nsamp;
    endfunction

    // Number of whole event blocks the ring buffer holds.
    function automatic int calc_nblk(input int addr_w, input int blk);
        return (1 << addr_w) / blk;
    endfunction

endpackage

// File: rtl/rb_evt_fifo.sv
// ----------------------------------------------------------------------------
// rb_evt_fifo
// Synchronous FIFO of completed-block start addresses for the readout side.
// DEPTH must be a power of two. A push into a full FIFO is only taken when a
// pop happens in the same cycle; a pop while empty is ignored.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   push       write push_data at the tail
//   push_data  block start address
//   pop        drop the head entry
//   valid      FIFO non-empty
//   head       oldest entry (0 while empty)
// ----------------------------------------------------------------------------
module rb_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    // NOTE: storage is deliberately not reset; every read is qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    assign valid = (count != '0);
    assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ringbuf_wr_sched.sv
// ----------------------------------------------------------------------------
// ringbuf_wr_sched
// Write-side scheduler for the 16-channel sample ring buffer. Turns the
// transfer datapath's per-word strobe into ring-buffer write addresses,
// groups words into fixed-size event blocks, tracks block occupancy against
// readout releases, throttles the transfer FSM and queues completed block
// start addresses for readout.
//
// Optional feature macro: RB_SCHED_OVFL_CNT_EN
//   defined   -> OVFL_CNT counts OVFL pulses, saturating at 16'hFFFF
//   undefined -> OVFL_CNT is tied to 0
//
// Ports:
//   CLK         system clock
//   RST         asynchronous active-high reset
//   JTAG_MODE   JTAG access active; freezes the write side
//   WREN        one sample word valid from the transfer datapath
//   RB_RD_DONE  pulse: readout finished the oldest block, frees it
//   EVT_ACK     pop event queue head
//   RB_WE       ring buffer write enable (registered)
//   RB_WADDR    ring buffer write address (registered)
//   XFER_HOLD   stall request to the transfer FSM (registered)
//   BLK_DONE    pulse on block completion
//   EVT_VALID   event queue non-empty
//   EVT_ADDR    start address of the oldest unacknowledged block
//   OCC         blocks written and not yet freed
//   OVFL        pulse: WREN dropped for lack of space
//   RD_ERR      sticky: RB_RD_DONE seen while OCC == 0
//   OVFL_CNT    overflow counter
// ----------------------------------------------------------------------------
module ringbuf_wr_sched
    import rb_sched_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NCHAN       = NCHAN_DEF,
    parameter int NSAMP       = NSAMP_DEF,
    parameter int HOLD_MARGIN = HOLD_MARGIN_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              JTAG_MODE,
    input  logic              WREN,
    input  logic              RB_RD_DONE,
    input  logic              EVT_ACK,
    output logic              RB_WE,
    output logic [ADDR_W-1:0] RB_WADDR,
    output logic              XFER_HOLD,
    output logic              BLK_DONE,
    output logic              EVT_VALID,
    output logic [ADDR_W-1:0] EVT_ADDR,
    output logic [ADDR_W:0]   OCC,
    output logic              OVFL,
    output logic              RD_ERR,
    output logic [15:0]       OVFL_CNT
);

    localparam int BLK   = calc_blk(NCHAN, NSAMP);
    localparam int NBLK  = calc_nblk(ADDR_W, BLK);
    localparam int BLK_W = $clog2(BLK);
    localparam int PTR_W = $clog2(NBLK);
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0] BLK_WORDS   = CNT_W'(BLK);
    localparam logic [CNT_W-1:0] TOTAL_WORDS = CNT_W'(NBLK * BLK);
    localparam logic [CNT_W-1:0] NBLK_CNT    = CNT_W'(NBLK);

    state_t             state;
    logic [BLK_W-1:0]   wcnt;
    logic [PTR_W-1:0]   blk_ptr;
    logic [CNT_W-1:0]   occ;

    logic [CNT_W-1:0]   free_words;
    logic [CNT_W-1:0]   free_next;
    logic [BLK_W-1:0]   wcnt_next;
    logic [CNT_W-1:0]   occ_next;
    logic               accept;
    logic               reject;
    logic               complete;
    logic               rd_ok;
    logic               rd_bad;

    // Space accounting counts the partially written block as occupied, so a
    // block can never overwrite one the readout has not released yet.
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        free_words = TOTAL_WORDS - (occ * BLK_WORDS + CNT_W'(wcnt));
        accept     = WREN && !JTAG_MODE && (free_words != '0);
        reject     = WREN && !JTAG_MODE && (free_words == '0);
        complete   = accept && (wcnt == BLK_W'(BLK - 1));
        rd_ok      = RB_RD_DONE && (occ != '0);
        rd_bad     = RB_RD_DONE && (occ == '0);

        wcnt_next = wcnt;
        if (accept) begin
            wcnt_next = complete ? '0 : wcnt + BLK_W'(1);
        end

        // Completion and release in the same cycle cancel out.
        occ_next = occ;
        if (complete && !rd_ok) begin
            occ_next = occ + CNT_W'(1);
        end else if (!complete && rd_ok) begin
            occ_next = occ - CNT_W'(1);
        end

        // Hold is judged on the space left after this cycle's updates.
        free_next = TOTAL_WORDS - (occ_next * BLK_WORDS + CNT_W'(wcnt_next));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            wcnt      <= '0;
            blk_ptr   <= '0;
            occ       <= '0;
            RB_WE     <= 1'b0;
            RB_WADDR  <= '0;
            XFER_HOLD <= 1'b0;
            BLK_DONE  <= 1'b0;
            OVFL      <= 1'b0;
            RD_ERR    <= 1'b0;
        end else begin
            RB_WE     <= accept;
            OVFL      <= reject;
            BLK_DONE  <= complete;
            XFER_HOLD <= (free_next <= CNT_W'(HOLD_MARGIN)) || JTAG_MODE;
            if (accept) begin
                // BLK and NBLK are powers of two, so ptr*BLK + wcnt is a concatenation.
                RB_WADDR <= {blk_ptr, wcnt};
            end
            if (rd_bad) begin
                RD_ERR <= 1'b1;
            end

            wcnt <= wcnt_next;
            occ  <= occ_next;
            if (complete) begin
                blk_ptr <= blk_ptr + PTR_W'(1);
            end

            unique case (state)
                IDLE, FILL: begin
                    if (complete) begin
                        state <= (occ_next == NBLK_CNT) ? FULL : IDLE;
                    end else if (accept) begin
                        state <= FILL;
                    end
                end
                FULL: begin
                    if (occ_next < NBLK_CNT) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign OCC = occ;

    rb_evt_fifo #(
        .DEPTH (NBLK),
        .W     (ADDR_W)
    ) u_evt_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (complete),
        .push_data ({blk_ptr, {BLK_W{1'b0}}}),
        .pop       (EVT_ACK),
        .valid     (EVT_VALID),
        .head      (EVT_ADDR)
    );

`ifdef RB_SCHED_OVFL_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVFL_CNT <= '0;
        end else if (reject && (OVFL_CNT != 16'hFFFF)) begin
            OVFL_CNT <= OVFL_CNT + 16'd1;
        end
    end
`else
    assign OVFL_CNT = '0;
`endif

endmodule

// File: tb/tb_ringbuf_wr_sched.sv
// ----------------------------------------------------------------------------
// tb_ringbuf_wr_sched
// Self-checking bench for ringbuf_wr_sched at default parameters
// (BLK = 128 words, NBLK = 8 blocks, 1024-word ring).
// Every cycle the DUT outputs are compared with a reference model that keeps
// the ring as a running word address, an occupied-block count and a queue of
// block start addresses. A short vector table and hand-written sequences add
// explicitly derived expectations for the corner cases.
// ----------------------------------------------------------------------------
module tb_ringbuf_wr_sched;
    import rb_sched_pkg::*;

    localparam int ADDR_W      = 10;
    localparam int DEPTH       = 1 << ADDR_W;
    localparam int BLK         = 16 * 8;
    localparam int NBLK        = DEPTH / BLK;
    localparam int HOLD_MARGIN = 4;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic jtag_mode = 1'b0;
    logic wren      = 1'b0;
    logic rd_done   = 1'b0;
    logic evt_ack   = 1'b0;

    logic        rb_we;
    rb_addr_t    rb_waddr;
    logic        xfer_hold;
    logic        blk_done;
    logic        evt_valid;
    rb_addr_t    evt_addr;
    logic [10:0] occ;
    logic        ovfl;
    logic        rd_err;
    logic [15:0] ovfl_cnt;

    ringbuf_wr_sched dut (
        .CLK        (clk),
        .RST        (rst),
        .JTAG_MODE  (jtag_mode),
        .WREN       (wren),
        .RB_RD_DONE (rd_done),
        .EVT_ACK    (evt_ack),
        .RB_WE      (rb_we),
        .RB_WADDR   (rb_waddr),
        .XFER_HOLD  (xfer_hold),
        .BLK_DONE   (blk_done),
        .EVT_VALID  (evt_valid),
        .EVT_ADDR   (evt_addr),
        .OCC        (occ),
        .OVFL       (ovfl),
        .RD_ERR     (rd_err),
        .OVFL_CNT   (ovfl_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int m_addr;      // next ring address to write (running, mod DEPTH)
    int m_occ;       // completed blocks not yet released
    bit m_rd_err;
    int m_cnt;       // overflow count
    int evq[$];      // start addresses of unacknowledged blocks
    int m_acked;
    int m_freed;
    bit e_we, e_ovfl, e_blk_done, e_hold;
    int e_waddr;

    task automatic m_reset();
        m_addr = 0; m_occ = 0; m_rd_err = 0; m_cnt = 0;
        m_acked = 0; m_freed = 0;
        evq.delete();
        e_we = 0; e_ovfl = 0; e_blk_done = 0; e_hold = 0; e_waddr = 0;
    endtask

    task automatic m_step();
        int  free_now;
        int  free_after;
        bit  acc, rej, cmpl, rd_ok;
        free_now = DEPTH - m_occ * BLK - (m_addr % BLK);
        acc   = wren && !jtag_mode && (free_now > 0);
        rej   = wren && !jtag_mode && (free_now == 0);
        cmpl  = acc && ((m_addr % BLK) == BLK - 1);
        rd_ok = rd_done && (m_occ > 0);

        e_we       = acc;
        e_waddr    = m_addr;
        e_ovfl     = rej;
        e_blk_done = cmpl;
        if (rd_done && m_occ == 0) m_rd_err = 1;

        if (evt_ack && evq.size() > 0) begin
            evq.delete(0);
            m_acked++;
        end
        if (cmpl) evq.push_back(m_addr - (BLK - 1));

        m_occ = m_occ + (cmpl ? 1 : 0) - (rd_ok ? 1 : 0);
        if (rd_ok) m_freed++;
        if (acc) m_addr = (m_addr + 1) % DEPTH;
        if (rej && m_cnt < 65535) m_cnt++;

        free_after = DEPTH - m_occ * BLK - (m_addr % BLK);
        e_hold = (free_after <= HOLD_MARGIN) || jtag_mode;
    endtask

    task automatic compare_model();
        int exp_cnt;
`ifdef RB_SCHED_OVFL_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        check("rb_we", rb_we, e_we);
        if (e_we) check("rb_waddr", rb_waddr, e_waddr);
        check("ovfl", ovfl, e_ovfl);
        check("blk_done", blk_done, e_blk_done);
        check("xfer_hold", xfer_hold, e_hold);
        check("evt_valid", evt_valid, evq.size() != 0);
        if (evq.size() != 0) check("evt_addr", evt_addr, evq[0]);
        check("occ", occ, m_occ);
        check("rd_err", rd_err, m_rd_err);
        check("ovfl_cnt", ovfl_cnt, exp_cnt);
    endtask

    // One clock: model advances on the edge, DUT sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        wren = 0; rd_done = 0; evt_ack = 0; jtag_mode = 0;
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases
    // it on a falling edge and returns there.
    task automatic do_reset();
        idle_inputs();
        rst = 1;
        #2;
        check("reset_outputs",
              {21'd0, rb_we, rb_waddr, xfer_hold, blk_done, evt_valid, ovfl, rd_err},
              32'd0);
        check("reset_evt_occ_cnt", {evt_addr, occ, ovfl_cnt[10:0]}, 32'd0);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       wren;
        logic       rd_done;
        logic       ack;
        logic       jtag;
        logic       we;
        logic [9:0] waddr;
        logic       ovfl;
        logic       hold;
        logic       valid;
        int         occ;
        logic       rd_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int  blk_pulses;
        int  occ_before;
        int  exp_cnt;
        int  rd_div;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 10'd1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1,  1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 10'd2, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 10'd3, 1'b0, 1'b0, 1'b0, 0, 1'b1};

        #3;
        do_reset();

        // Table: basic writes, JTAG freeze, ack on empty queue, release at OCC 0.
        for (int i = 0; i < 8; i++) begin
            wren = vecs[i].wren; rd_done = vecs[i].rd_done;
            evt_ack = vecs[i].ack; jtag_mode = vecs[i].jtag;
            tick();
            check($sformatf("vec%0d_we", i), rb_we, vecs[i].we);
            if (vecs[i].we) check($sformatf("vec%0d_waddr", i), rb_waddr, vecs[i].waddr);
            check($sformatf("vec%0d_ovfl", i), ovfl, vecs[i].ovfl);
            check($sformatf("vec%0d_hold", i), xfer_hold, vecs[i].hold);
            check($sformatf("vec%0d_valid", i), evt_valid, vecs[i].valid);
            check($sformatf("vec%0d_occ", i), occ, vecs[i].occ);
            check($sformatf("vec%0d_rd_err", i), rd_err, vecs[i].rd_err);
        end
        idle_inputs();
        tick();
        do_reset();

        // One full block: addresses 0..127, one BLK_DONE, queued at 0.
        blk_pulses = 0;
        wren = 1;
        for (int i = 0; i < BLK; i++) begin
            tick();
            check("blk1_we", rb_we, 1);
            check("blk1_waddr", rb_waddr, i);
            if (blk_done) blk_pulses++;
        end
        wren = 0;
        tick();
        if (blk_done) blk_pulses++;
        check("blk1_done_pulses", blk_pulses, 1);
        check("blk1_occ", occ, 1);
        check("blk1_evt_valid", evt_valid, 1);
        check("blk1_evt_addr", evt_addr, 0);

        // Fill the remaining seven blocks; hold rises once word 1020 is in.
        wren = 1;
        for (int i = BLK; i < DEPTH; i++) begin
            tick();
            if (i == 1018) check("hold_before_margin", xfer_hold, 0);
            if (i == 1019) check("hold_at_margin", xfer_hold, 1);
        end
        check("full_occ", occ, NBLK);
        tick();   // word 1025: no space
        check("full_ovfl", ovfl, 1);
        check("full_we", rb_we, 0);
        check("full_occ_after_ovfl", occ, NBLK);
`ifdef RB_SCHED_OVFL_CNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        check("full_ovfl_cnt", ovfl_cnt, exp_cnt);

        // Release one block: space returns, next write wraps to address 0.
        wren = 0; rd_done = 1; evt_ack = 1;
        tick();
        rd_done = 0; evt_ack = 0;
        check("release_occ", occ, NBLK - 1);
        check("release_hold", xfer_hold, 0);
        wren = 1;
        for (int i = 0; i < BLK; i++) begin
            if (i == BLK - 1) begin
                occ_before = occ;
                rd_done = 1; evt_ack = 1;
            end
            tick();
            if (i == 0) check("wrap_waddr", rb_waddr, 0);
        end
        idle_inputs();
        check("done_and_release_occ", occ, occ_before);
        check("done_and_release_blk_done", blk_done, 1);
        tick();

        // Release with nothing occupied: sticky error, OCC stays 0.
        do_reset();
        rd_done = 1;
        tick();
        rd_done = 0;
        check("rd_err_set", rd_err, 1);
        check("rd_err_occ", occ, 0);
        repeat (3) tick();
        check("rd_err_sticky", rd_err, 1);

        // JTAG freeze at wcnt = 50.
        wren = 1;
        repeat (50) tick();
        jtag_mode = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("jtag_we", rb_we, 0);
            check("jtag_ovfl", ovfl, 0);
            check("jtag_hold", xfer_hold, 1);
        end
        jtag_mode = 0;
        tick();
        check("jtag_resume_we", rb_we, 1);
        check("jtag_resume_waddr", rb_waddr, 50);

        // Reset mid-block: partial block discarded, restart at 0.
        repeat (20) tick();
        do_reset();
        wren = 1;
        tick();
        check("post_reset_waddr", rb_waddr, 0);
        check("post_reset_we", rb_we, 1);
        idle_inputs();
        tick();

        // Randomized traffic against the model, varying the readout rate so
        // both the starved and the full regimes are visited.
        do_reset();
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0: rd_div = 60;
                1: rd_div = 600;
                2: rd_div = 150;
                default: rd_div = 2000;
            endcase
            for (int c = 0; c < 1500; c++) begin
                wren      = ($urandom % 4) != 0;
                jtag_mode = ($urandom % 20) == 0;
                evt_ack   = ($urandom % 3) == 0;
                // Readout only releases blocks it has acknowledged.
                rd_done   = (($urandom % rd_div) < 3) && (m_freed < m_acked);
                tick();
            end
        end
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
